// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- constants shared by the ALU controller, its register file and
//            the external ALU.
//   * alu_op_e  : 3-bit ALU opcode encoding (ADD..AND)
//   * ST_*      : FSM state encodings of the controller
//   * is_div    : helper that recognises the divide opcode
// Related build macro: DIV0_CHECK_EN (used in alu_ctrl.sv).
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_NOT = 3'd4,
        OP_XOR = 3'd5,
        OP_OR  = 3'd6,
        OP_AND = 3'd7
    } alu_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_div(input logic [2:0] oc);
        return oc == OP_DIV;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_if -- bundle of every non-clock signal of alu_ctrl.
//   command channel : cmd_valid/cmd_ready, cmd_oc, cmd_dst, cmd_src_a, cmd_src_b
//   direct load     : ld_en, ld_addr, ld_data
//   external ALU    : alu_oc, alu_a, alu_b (to ALU), alu_f (from ALU)
//   response channel: rsp_valid/rsp_ready, rsp_data, rsp_dst, rsp_err
// Modports:
//   slave  -- the controller side
//   master -- the environment side (command source, ALU, response sink)
// -----------------------------------------------------------------------------
interface alu_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int REG_AW = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_oc;
    logic [REG_AW-1:0] cmd_dst;
    logic [REG_AW-1:0] cmd_src_a;
    logic [REG_AW-1:0] cmd_src_b;
    logic              ld_en;
    logic [REG_AW-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [2:0]        alu_oc;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_f;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [REG_AW-1:0] rsp_dst;
    logic              rsp_err;

    modport slave (
        input  cmd_valid, cmd_oc, cmd_dst, cmd_src_a, cmd_src_b,
        input  ld_en, ld_addr, ld_data,
        input  alu_f, rsp_ready,
        output cmd_ready, alu_oc, alu_a, alu_b,
        output rsp_valid, rsp_data, rsp_dst, rsp_err
    );

    modport master (
        output cmd_valid, cmd_oc, cmd_dst, cmd_src_a, cmd_src_b,
        output ld_en, ld_addr, ld_data,
        output alu_f, rsp_ready,
        input  cmd_ready, alu_oc, alu_a, alu_b,
        input  rsp_valid, rsp_data, rsp_dst, rsp_err
    );
endinterface

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile -- 2**REG_AW x DATA_W register file.
//   clk, rst                 : clock, synchronous active-high clear of all regs
//   rd_addr_a/rd_data_a      : asynchronous read port A
//   rd_addr_b/rd_data_b      : asynchronous read port B
//   wr_en_hi/addr/data_hi    : high-priority write port (ALU writeback)
//   wr_en_lo/addr/data_lo    : low-priority write port (direct load)
// Reads are combinational from the current contents, so a read in the same
// cycle as a write returns the old value.
// -----------------------------------------------------------------------------
module alu_regfile #(
    parameter int DATA_W = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en_hi,
    input  logic [REG_AW-1:0] wr_addr_hi,
    input  logic [DATA_W-1:0] wr_data_hi,
    input  logic              wr_en_lo,
    input  logic [REG_AW-1:0] wr_addr_lo,
    input  logic [DATA_W-1:0] wr_data_lo
);
    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] mem_reg [NREG];
    logic [NREG-1:0]   sel_hi;
    logic [NREG-1:0]   sel_lo;

    // One-hot write decode per port.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
        assign sel_hi[gi] = wr_en_hi && (wr_addr_hi == REG_AW'(gi));
        assign sel_lo[gi] = wr_en_lo && (wr_addr_lo == REG_AW'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                mem_reg[i] <= '0;
            end else if (sel_hi[i]) begin
                mem_reg[i] <= wr_data_hi;
            end else if (sel_lo[i]) begin
                mem_reg[i] <= wr_data_lo;
            end
        end
    end

    assign rd_data_a = mem_reg[rd_addr_a];
    assign rd_data_b = mem_reg[rd_addr_b];

endmodule

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl -- sequences register-file operands through an external
//             combinational ALU and writes the result back.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_ctrl_if.slave (command, direct load, ALU and response signals)
// Flow: IDLE accepts a command and latches operands, EXEC presents them to the
// ALU for one cycle and captures/writes back alu_f, RESP holds the result
// until rsp_ready.
// Build macro DIV0_CHECK_EN: when defined, a DIV with a zero divisor returns
// all-ones with rsp_err=1 and leaves the destination register untouched.
// -----------------------------------------------------------------------------
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int REG_AW = 2
) (
    input  logic     clk,
    input  logic     rst,
    alu_ctrl_if.slave bus
);
    logic [1:0]        state_reg;
    logic [2:0]        oc_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [REG_AW-1:0] dst_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic [REG_AW-1:0] rsp_dst_reg;
    logic              rsp_err_reg;

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              div0;
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;

`ifdef DIV0_CHECK_EN
    assign div0 = is_div(oc_reg) && (b_reg == '0);
`else
    assign div0 = 1'b0;
`endif

    assign wb_data = div0 ? '1 : bus.alu_f;
    // A reset in the same cycle also wins inside the register file, which
    // discards the writeback of an interrupted command.
    assign wb_en   = (state_reg == ST_EXEC) && !div0;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_a  (bus.cmd_src_a),
        .rd_data_a  (rd_a),
        .rd_addr_b  (bus.cmd_src_b),
        .rd_data_b  (rd_b),
        .wr_en_hi   (wb_en),
        .wr_addr_hi (dst_reg),
        .wr_data_hi (wb_data),
        .wr_en_lo   (bus.ld_en),
        .wr_addr_lo (bus.ld_addr),
        .wr_data_lo (bus.ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            oc_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            dst_reg      <= '0;
            rsp_data_reg <= '0;
            rsp_dst_reg  <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        oc_reg    <= bus.cmd_oc;
                        a_reg     <= rd_a;
                        b_reg     <= rd_b;
                        dst_reg   <= bus.cmd_dst;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_reg <= wb_data;
                    rsp_dst_reg  <= dst_reg;
                    rsp_err_reg  <= div0;
                    // ALU operands are only valid during EXEC.
                    oc_reg       <= '0;
                    a_reg        <= '0;
                    b_reg        <= '0;
                    state_reg    <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_reg == ST_IDLE);
    assign bus.rsp_valid = (state_reg == ST_RESP);
    assign bus.alu_oc    = oc_reg;
    assign bus.alu_a     = a_reg;
    assign bus.alu_b     = b_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_dst   = rsp_dst_reg;
`ifdef DIV0_CHECK_EN
    assign bus.rsp_err   = rsp_err_reg;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl -- directed bench for alu_ctrl (DATA_W=4, REG_AW=2).
// Supplies a behavioural 4-bit ALU on alu_f; register contents are observed
// by issuing AND r,r,r commands and looking at the operands sent to the ALU.
// Expected results follow DIV0_CHECK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_ctrl_if #(.DATA_W(4), .REG_AW(2)) bus ();

    alu_ctrl #(.DATA_W(4), .REG_AW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU: results truncated to 4 bits; divide by zero yields 0.
    always_comb begin
        bus.alu_f = '0;
        case (bus.alu_oc)
            3'd0: bus.alu_f = bus.alu_a + bus.alu_b;
            3'd1: bus.alu_f = bus.alu_a - bus.alu_b;
            3'd2: bus.alu_f = bus.alu_a * bus.alu_b;
            3'd3: bus.alu_f = (bus.alu_b == 4'd0) ? 4'd0 : bus.alu_a / bus.alu_b;
            3'd4: bus.alu_f = ~bus.alu_a;
            3'd5: bus.alu_f = bus.alu_a ^ bus.alu_b;
            3'd6: bus.alu_f = bus.alu_a | bus.alu_b;
            default: bus.alu_f = bus.alu_a & bus.alu_b;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic load(input logic [1:0] addr, input logic [3:0] data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = addr;
        bus.ld_data = data;
        step();
        bus.ld_en   = 1'b0;
    endtask

    // Full command transaction with optional direct loads in the accept cycle
    // and in the EXEC cycle.
    task automatic issue(input string tag, input logic [2:0] oc,
                         input logic [1:0] dst, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [3:0] exp_a, input logic [3:0] exp_b,
                         input logic [3:0] exp_data, input logic exp_err,
                         input bit acc_ld, input logic [1:0] acc_addr, input logic [3:0] acc_data,
                         input bit ex_ld, input logic [1:0] ex_addr, input logic [3:0] ex_data);
        check({tag, ".cmd_ready"}, 8'(bus.cmd_ready), 8'h1);
        bus.cmd_valid = 1'b1;
        bus.cmd_oc    = oc;
        bus.cmd_dst   = dst;
        bus.cmd_src_a = sa;
        bus.cmd_src_b = sb;
        bus.ld_en     = acc_ld;
        bus.ld_addr   = acc_addr;
        bus.ld_data   = acc_data;
        step();                                   // accepted; now EXEC
        bus.cmd_valid = 1'b0;
        bus.ld_en     = ex_ld;
        bus.ld_addr   = ex_addr;
        bus.ld_data   = ex_data;
        check({tag, ".exec_ready"}, 8'(bus.cmd_ready), 8'h0);
        check({tag, ".exec_valid"}, 8'(bus.rsp_valid), 8'h0);
        check({tag, ".alu_oc"}, 8'(bus.alu_oc), 8'(oc));
        check({tag, ".alu_a"}, 8'(bus.alu_a), 8'(exp_a));
        check({tag, ".alu_b"}, 8'(bus.alu_b), 8'(exp_b));
        step();                                   // RESP (t+2)
        bus.ld_en = 1'b0;
        check({tag, ".rsp_valid"}, 8'(bus.rsp_valid), 8'h1);
        check({tag, ".rsp_data"}, 8'(bus.rsp_data), 8'(exp_data));
        check({tag, ".rsp_dst"}, 8'(bus.rsp_dst), 8'(dst));
        check({tag, ".rsp_err"}, 8'(bus.rsp_err), 8'(exp_err));
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 8'(bus.rsp_valid), 8'h0);
    endtask

    // Observe register r: AND r,r,r sends r to the ALU and writes it back unchanged.
    task automatic read_reg(input string tag, input logic [1:0] r, input logic [3:0] exp);
        issue(tag, OP_AND, r, r, r, exp, exp, exp, 1'b0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_oc    = '0;
        bus.cmd_dst   = '0;
        bus.cmd_src_a = '0;
        bus.cmd_src_b = '0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst.cmd_ready", 8'(bus.cmd_ready), 8'h1);
        check("rst.rsp_valid", 8'(bus.rsp_valid), 8'h0);
        check("rst.rsp_data", 8'(bus.rsp_data), 8'h0);
        check("rst.rsp_dst", 8'(bus.rsp_dst), 8'h0);
        check("rst.rsp_err", 8'(bus.rsp_err), 8'h0);
        check("rst.alu_oc", 8'(bus.alu_oc), 8'h0);
        check("rst.alu_a", 8'(bus.alu_a), 8'h0);
        check("rst.alu_b", 8'(bus.alu_b), 8'h0);
        rst = 1'b0;

        // 3 + 5 = 8 into r2
        load(2'd0, 4'd3);
        load(2'd1, 4'd5);
        issue("add", OP_ADD, 2'd2, 2'd0, 2'd1, 4'd3, 4'd5, 4'd8, 1'b0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0);
        read_reg("rd_r2_add", 2'd2, 4'd8);

        // 9 * 9 = 81 -> 1 (mod 16) into r0, then r0 - r0 = 0 into r3
        load(2'd0, 4'd9);
        load(2'd1, 4'd9);
        issue("mul", OP_MUL, 2'd0, 2'd0, 2'd1, 4'd9, 4'd9, 4'd1, 1'b0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0);
        read_reg("rd_r0_mul", 2'd0, 4'd1);
        issue("sub", OP_SUB, 2'd3, 2'd0, 2'd0, 4'd1, 4'd1, 4'd0, 1'b0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0);
        read_reg("rd_r3_sub", 2'd3, 4'd0);

        // Back-pressure: 2 ^ 6 = 4 into r1, response held 5 cycles while a
        // second command (ADD r0 <- r0 + r0) is offered and must be ignored.
        load(2'd0, 4'd2);
        load(2'd1, 4'd6);
        bus.cmd_valid = 1'b1;
        bus.cmd_oc    = OP_XOR;
        bus.cmd_dst   = 2'd1;
        bus.cmd_src_a = 2'd0;
        bus.cmd_src_b = 2'd1;
        step();
        bus.cmd_oc    = OP_ADD;
        bus.cmd_dst   = 2'd0;
        bus.cmd_src_a = 2'd0;
        bus.cmd_src_b = 2'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d.rsp_valid", i), 8'(bus.rsp_valid), 8'h1);
            check($sformatf("hold%0d.rsp_data", i), 8'(bus.rsp_data), 8'h4);
            check($sformatf("hold%0d.cmd_ready", i), 8'(bus.cmd_ready), 8'h0);
            step();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("hold.done_valid", 8'(bus.rsp_valid), 8'h0);
        check("hold.done_ready", 8'(bus.cmd_ready), 8'h1);
        read_reg("rd_r0_hold", 2'd0, 4'd2);
        read_reg("rd_r1_hold", 2'd1, 4'd4);

        // Writeback beats a same-cycle load to r2; load to r0 at accept
        // does not disturb the operand read.
        load(2'd0, 4'd1);
        load(2'd1, 4'd2);
        issue("wb_win", OP_ADD, 2'd2, 2'd0, 2'd1, 4'd1, 4'd2, 4'd3, 1'b0, 0, 2'd0, 4'd0, 1, 2'd2, 4'd7);
        read_reg("rd_r2_win", 2'd2, 4'd3);
        issue("rbw", OP_OR, 2'd3, 2'd0, 2'd1, 4'd1, 4'd2, 4'd3, 1'b0, 1, 2'd0, 4'hF, 0, 2'd0, 4'd0);
        read_reg("rd_r0_rbw", 2'd0, 4'hF);
        read_reg("rd_r3_rbw", 2'd3, 4'd3);

        // Load during EXEC to a different register lands.
        issue("ld_exec", OP_NOT, 2'd2, 2'd1, 2'd1, 4'd2, 4'd2, 4'hD, 1'b0, 0, 2'd0, 4'd0, 1, 2'd3, 4'd9);
        read_reg("rd_r3_ldex", 2'd3, 4'd9);
        read_reg("rd_r2_not", 2'd2, 4'hD);

        // Divide by zero
        load(2'd0, 4'd8);
        load(2'd1, 4'd0);
        load(2'd2, 4'd4);
`ifdef DIV0_CHECK_EN
        issue("div0", OP_DIV, 2'd2, 2'd0, 2'd1, 4'd8, 4'd0, 4'hF, 1'b1, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0);
        read_reg("rd_r2_div0", 2'd2, 4'd4);
`else
        issue("div0", OP_DIV, 2'd2, 2'd0, 2'd1, 4'd8, 4'd0, 4'd0, 1'b0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0);
        read_reg("rd_r2_div0", 2'd2, 4'd0);
`endif
        // Ordinary divide: 8 / 2 = 4 into r3
        load(2'd1, 4'd2);
        issue("div", OP_DIV, 2'd3, 2'd0, 2'd1, 4'd8, 4'd2, 4'd4, 1'b0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0);

        // Reset while in EXEC discards the command.
        load(2'd0, 4'd1);
        load(2'd1, 4'd1);
        load(2'd2, 4'd5);
        bus.cmd_valid = 1'b1;
        bus.cmd_oc    = OP_ADD;
        bus.cmd_dst   = 2'd2;
        bus.cmd_src_a = 2'd0;
        bus.cmd_src_b = 2'd1;
        step();
        bus.cmd_valid = 1'b0;
        check("rexec.in_exec", 8'(bus.alu_a), 8'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rexec.cmd_ready", 8'(bus.cmd_ready), 8'h1);
        check("rexec.rsp_valid", 8'(bus.rsp_valid), 8'h0);
        check("rexec.rsp_data", 8'(bus.rsp_data), 8'h0);
        check("rexec.alu_a", 8'(bus.alu_a), 8'h0);
        step();
        check("rexec.still_idle", 8'(bus.rsp_valid), 8'h0);
        read_reg("rd_r2_rexec", 2'd2, 4'd0);
        read_reg("rd_r0_rexec", 2'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
